instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 32 +++
 rtl/instr_mem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg
// Shared definitions for the instruction memory loader:
//   - state_t            : loader FSM state enumeration
//   - SYNC_BYTE_DEFAULT  : default frame start marker
//   - SRC_* / DST_*      : source/destination register field positions
//                          inside an instruction byte
//   - chk_fold()         : running XOR checksum update
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Instruction byte layout: [7:4] source register, [3:0] destination register
  localparam int SRC_MSB = 7;
  localparam int SRC_LSB = 4;
  localparam int DST_MSB = 3;
  localparam int DST_LSB = 0;

  // Fold one byte into the frame checksum (plain XOR, seeded with zero)
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Receives a framed program image from a host byte stream and writes it
// into instruction memory while holding the processor core in reset.
// Frame: SYNC_BYTE, LEN, LEN instruction bytes, CHK (XOR of instruction bytes).
//
// Ports:
//   clk        : clock, all state changes on rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : host byte present
//   in_data    : host byte
//   in_ready   : loader accepts in_data this cycle
//   mem_we     : instruction memory write strobe (one cycle per data byte)
//   mem_addr   : instruction memory write address
//   mem_wdata  : instruction byte written
//   cpu_hold   : high keeps the processor core in reset
//   load_done  : one-cycle pulse after a frame with a good checksum
//   load_err   : one-cycle pulse after a bad length or bad checksum
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int         MEM_DEPTH = 16,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [8:0]      MAX_LEN_C = 9'(MEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE_C = (ADDR_W + 1)'(1);

  state_t            state_r;
  state_t            state_nx_s;
  logic              accept_s;
  logic              len_bad_s;

  // One extra counter bit so a full-depth frame never wraps the counter
  logic [ADDR_W:0]   cnt_r;
  logic [7:0]        chk_r;
  logic [7:0]        rem_r;

  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic              cpu_hold_r;
  logic              load_done_r;
  logic              load_err_r;

  logic              in_ready_nx_s;
  logic              mem_we_nx_s;
  logic [ADDR_W-1:0] mem_addr_nx_s;
  logic [7:0]        mem_wdata_nx_s;
  logic              cpu_hold_nx_s;
  logic              load_done_nx_s;
  logic              load_err_nx_s;

  assign accept_s  = in_valid & in_ready_r;
  assign len_bad_s = (in_data == 8'd0) || ({1'b0, in_data} > MAX_LEN_C);

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_hold  = cpu_hold_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // Anything other than the start marker is line noise and dropped
        if (accept_s && (in_data == SYNC_BYTE)) begin
          state_nx_s = ST_LEN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          state_nx_s = len_bad_s ? ST_ERR : ST_DATA;
        end else begin
          state_nx_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (accept_s && (rem_r == 8'd1)) begin
          state_nx_s = ST_CHK;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          state_nx_s = (in_data == chk_r) ? ST_DONE : ST_ERR;
        end else begin
          state_nx_s = ST_CHK;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs
  always_comb begin
    mem_we_nx_s    = 1'b0;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    load_done_nx_s = (state_nx_s == ST_DONE);
    load_err_nx_s  = (state_nx_s == ST_ERR);
    in_ready_nx_s  = (state_nx_s != ST_DONE) && (state_nx_s != ST_ERR);

    if ((state_r == ST_DATA) && accept_s) begin
      mem_we_nx_s    = 1'b1;
      mem_addr_nx_s  = cnt_r[ADDR_W-1:0];
      mem_wdata_nx_s = {in_data[SRC_MSB:SRC_LSB], in_data[DST_MSB:DST_LSB]};
    end else begin
      mem_we_nx_s    = 1'b0;
    end

    // Hold rises on an accepted start marker, falls only on a good frame;
    // a bad frame leaves the core held
    if ((state_r == ST_IDLE) && (state_nx_s == ST_LEN)) begin
      cpu_hold_nx_s = 1'b1;
    end else if (state_nx_s == ST_DONE) begin
      cpu_hold_nx_s = 1'b0;
    end else begin
      cpu_hold_nx_s = cpu_hold_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
      cpu_hold_r  <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
      cpu_hold_r  <= cpu_hold_nx_s;
      load_done_r <= load_done_nx_s;
      load_err_r  <= load_err_nx_s;
    end
  end

  // Address counter, running checksum and remaining-byte count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      chk_r <= 8'd0;
      rem_r <= 8'd0;
    end else begin
      case (state_r)
        ST_LEN: begin
          if (accept_s) begin
            cnt_r <= '0;
            chk_r <= 8'd0;
            rem_r <= in_data;
          end else begin
            cnt_r <= cnt_r;
            chk_r <= chk_r;
            rem_r <= rem_r;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            cnt_r <= cnt_r + CNT_ONE_C;
            chk_r <= chk_fold(chk_r, in_data);
            rem_r <= rem_r - 8'd1;
          end else begin
            cnt_r <= cnt_r;
            chk_r <= chk_r;
            rem_r <= rem_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
          chk_r <= chk_r;
          rem_r <= rem_r;
        end
      endcase
    end
  end

endmodule
